dport_arbiter: RTL

Shares the single data port of the unified 1024x16 program/data memory between two requesters: the processor's load/store path (requester 0, CPU) and an external host/debug loader (requester 1, HOST). It uses registered round-robin grants, a bounded hold time with preemption, and an optional lock for host bursts. It sits between the processor and memory data-port signals and raises a stall for the CPU while the CPU is waiting.

---
 rtl/dport_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dport_arbiter
// Purpose  : Round-robin arbiter for the shared memory data port (CPU/HOST),
//            with bounded hold, preemption and a HOST burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module dport_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          cpu_stall,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_CPU  = 2'd1,
        ST_OWN_HOST = 2'd2
    } state_t;

    localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic           OWNER_CPU  = 1'b0;
    localparam logic           OWNER_HOST = 1'b1;

    state_t         state_q, state_d;
    logic           last_owner_q, last_owner_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           hold_expired;
    logic           owner_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_HOST;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign hold_expired = (hold_cnt_q == HOLD_LAST);

    // A releasing owner hands over directly to a waiting requester, no IDLE bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req && host_req) begin
                    state_d = (last_owner_q == OWNER_HOST) ? ST_OWN_CPU : ST_OWN_HOST;
                end else if (cpu_req) begin
                    state_d = ST_OWN_CPU;
                end else if (host_req) begin
                    state_d = ST_OWN_HOST;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_req) begin
                    state_d = host_req ? ST_OWN_HOST : ST_IDLE;
                end else if (host_req && hold_expired) begin
                    state_d = ST_OWN_HOST;
                end
            end
            ST_OWN_HOST: begin
                if (!host_req) begin
                    state_d = cpu_req ? ST_OWN_CPU : ST_IDLE;
                end else if (cpu_req && !host_lock && hold_expired) begin
                    state_d = ST_OWN_CPU;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign owner_change = (state_d != state_q) && (state_d != ST_IDLE);

    always_comb begin
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        if (owner_change) begin
            last_owner_d = (state_d == ST_OWN_HOST) ? OWNER_HOST : OWNER_CPU;
            hold_cnt_d   = '0;
        end else if (state_d == ST_IDLE) begin
            hold_cnt_d   = '0;
        end else if (!hold_expired) begin
            hold_cnt_d   = hold_cnt_q + 1'b1;
        end
    end

    assign cpu_gnt  = (state_q == ST_OWN_CPU);
    assign host_gnt = (state_q == ST_OWN_HOST);

    // Grants decode the asynchronously reset state, so reset kills any write at once.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_req & host_we;
        end
    end

    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign cpu_rvalid  = cpu_gnt & cpu_req & ~cpu_we;
    assign host_rvalid = host_gnt & host_req & ~host_we;
    assign cpu_stall   = cpu_req & ~cpu_gnt;

endmodule
`default_nettype wire
